// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, the zero register, the control-bundle
// bubble and the ALU operation encodings used by decode, EX and the ALU.
package pipe_pkg;

    localparam int RW = 4;
    localparam int DW = 16;

    localparam logic [RW-1:0] REG_ZERO = 4'b0;

    typedef struct packed {
        logic reg_write;
        logic mr;
        logic mw;
        logic alu_src;
        logic valid;
    } ctrl_t;

    // A bubble never writes the register file or touches memory.
    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_e;

endpackage

// File: rtl/id_ex_hazard_stage_load_use_detect.sv
// Load-use hazard equation: the instruction in ID reads the register a load
// in EX is about to produce, so it must wait one cycle.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int RW = 4
) (
    input  logic          id_valid,
    input  logic [RW-1:0] id_rn1,
    input  logic [RW-1:0] id_rn2,
    input  logic          id_use1,
    input  logic          id_use2,
    input  logic          ex_valid,
    input  logic          ex_mr,
    input  logic [RW-1:0] ex_wn,
    input  logic          ex_flush,
    output logic          stall
);

    logic hit1;
    logic hit2;

    // Register 0 is never a real producer; a flush already squashes ID.
    always_comb begin
        hit1  = id_use1 && (id_rn1 == ex_wn);
        hit2  = id_use2 && (id_rn2 == ex_wn);
        stall = id_valid && ex_valid && ex_mr && (ex_wn != RW'(REG_ZERO))
                && (hit1 || hit2) && !ex_flush;
    end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// a saturating count of bubbles caused by load-use stalls.
module id_ex_hazard_stage
    import pipe_pkg::*;
#(
    parameter int DW   = 16,
    parameter int RW   = 4,
    parameter int AOPW = 4,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rn1,
    input  logic [RW-1:0]   id_rn2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [RW-1:0]   id_wn,
    input  logic [DW-1:0]   id_rd1,
    input  logic [DW-1:0]   id_rd2,
    input  logic [DW-1:0]   id_imm,
    input  logic            id_RegWrite,
    input  logic            id_MR,
    input  logic            id_MW,
    input  logic            id_ALUSrc,
    input  logic [AOPW-1:0] id_alu_op,
    input  logic            ex_flush,
    output logic [RW-1:0]   ID_EX_rn1,
    output logic [RW-1:0]   ID_EX_rn2,
    output logic [RW-1:0]   ID_EX_wn,
    output logic [DW-1:0]   ID_EX_rd1,
    output logic [DW-1:0]   ID_EX_rd2,
    output logic [DW-1:0]   ID_EX_imm,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MR,
    output logic            ID_EX_MW,
    output logic            ID_EX_ALUSrc,
    output logic            ID_EX_valid,
    output logic [AOPW-1:0] ID_EX_alu_op,
    output logic            stall,
    output logic [CW-1:0]   stall_count
);

    ctrl_t ctrl_p1;
    logic  hazard;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    load_use_detect #(.RW(RW)) u_detect (
        .id_valid (id_valid),
        .id_rn1   (id_rn1),
        .id_rn2   (id_rn2),
        .id_use1  (id_use1),
        .id_use2  (id_use2),
        .ex_valid (ctrl_p1.valid),
        .ex_mr    (ctrl_p1.mr),
        .ex_wn    (ID_EX_wn),
        .ex_flush (ex_flush),
        .stall    (hazard)
    );

    // Never ask the front end to hold while the pipeline is being reset.
    assign stall = hazard && !rst;

    assign ID_EX_RegWrite = ctrl_p1.reg_write;
    assign ID_EX_MR       = ctrl_p1.mr;
    assign ID_EX_MW       = ctrl_p1.mw;
    assign ID_EX_ALUSrc   = ctrl_p1.alu_src;
    assign ID_EX_valid    = ctrl_p1.valid;

    // ID -> EX boundary: capture, or load a fully cleared bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_p1      <= CTRL_BUBBLE;
            ID_EX_rn1    <= '0;
            ID_EX_rn2    <= '0;
            ID_EX_wn     <= '0;
            ID_EX_rd1    <= '0;
            ID_EX_rd2    <= '0;
            ID_EX_imm    <= '0;
            ID_EX_alu_op <= '0;
            stall_count  <= '0;
        end else begin
            if (ex_flush || stall || !id_valid) begin
                ctrl_p1      <= CTRL_BUBBLE;
                ID_EX_rn1    <= '0;
                ID_EX_rn2    <= '0;
                ID_EX_wn     <= '0;
                ID_EX_rd1    <= '0;
                ID_EX_rd2    <= '0;
                ID_EX_imm    <= '0;
                ID_EX_alu_op <= '0;
            end else begin
                ctrl_p1      <= '{reg_write: id_RegWrite, mr: id_MR, mw: id_MW,
                                  alu_src: id_ALUSrc, valid: 1'b1};
                ID_EX_rn1    <= id_rn1;
                ID_EX_rn2    <= id_rn2;
                ID_EX_wn     <= id_wn;
                ID_EX_rd1    <= id_rd1;
                ID_EX_rd2    <= id_rd2;
                ID_EX_imm    <= id_imm;
                ID_EX_alu_op <= id_alu_op;
            end
            if (stall) begin
                stall_count <= sat_inc(stall_count);
            end
        end
    end

endmodule
